// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - register map and bit positions shared by the tick timer
package tick_timer_pkg;

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_RELOAD = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  localparam int CTRL_AR  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_RUN = 2;

  localparam int STAT_EXP    = 0;
  localparam int STAT_ACTIVE = 1;

  localparam logic [2:0] CTRL_RESET = 3'b100;

endpackage

// File: rtl/tick_timer_channel.sv
// rtl/tick_timer_channel.sv - one down-counter channel with reload, sticky expiry and irq request
module tick_timer_channel
  import tick_timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         we_count,
  input  logic         we_reload,
  input  logic         we_ctrl,
  input  logic         we_status,
  input  logic [W-1:0] di,
  output logic [W-1:0] count,
  output logic [W-1:0] reload,
  output logic [2:0]   ctrl,
  output logic         exp,
  output logic         irq_req
);

  logic step;
  logic expire;

  // A COUNT write steals this channel's tick, so it can neither decrement nor expire.
  assign step   = tick && ctrl[CTRL_RUN] && !we_count;
  assign expire = step && (count == W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      reload <= '0;
      ctrl   <= CTRL_RESET;
      exp    <= 1'b0;
    end else begin
      if (we_count) begin
        count  <= di;
        reload <= di;
      end else begin
        if (we_reload)
          reload <= di;
        if (step && (count > W'(1)))
          count <= count - W'(1);
        else if (expire)
          count <= (ctrl[CTRL_AR] && (reload != '0)) ? reload : '0;
      end
      if (we_ctrl)
        ctrl <= di[2:0];
      // Set beats a coincident write-1-to-clear.
      if (expire)
        exp <= 1'b1;
      else if (we_status && di[STAT_EXP])
        exp <= 1'b0;
    end
  end

  assign irq_req = exp && ctrl[CTRL_IE];

endmodule

// File: rtl/tick_timer_multi.sv
// rtl/tick_timer_multi.sv - prescaler, register decode, read mux and irq for NCH timer channels
module tick_timer_multi
  import tick_timer_pkg::*;
#(
  parameter int  MCLKFREQ     = 24000000,
  parameter int  TICKHZ       = 100,
  parameter int  SIM_PRESCALE = 0,
  parameter int  NCH          = 4,
  parameter int  W            = 8,
  localparam int AW           = $clog2(NCH) + 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  di,
  input  logic          wren,
  input  logic          rden,
  output logic [W-1:0]  q,
  output logic          tick,
  output logic          irq
);

  localparam int PRESCALE = (SIM_PRESCALE != 0) ? SIM_PRESCALE : MCLKFREQ / TICKHZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic [AW-1:0] ch_sel;
  reg_e          reg_sel;
  logic [W-1:0]  rd_val;
  logic [W-1:0]  count_a  [NCH];
  logic [W-1:0]  reload_a [NCH];
  logic [2:0]    ctrl_a   [NCH];
  logic [NCH-1:0] exp_a;
  logic [NCH-1:0] irq_req_a;

  assign ch_sel  = addr >> 2;
  assign reg_sel = reg_e'(addr[1:0]);

  // Reloading from zero makes the first tick land on the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == '0) begin
      presc <= PW'(PRESCALE - 1);
      tick  <= 1'b1;
    end else begin
      presc <= presc - PW'(1);
      tick  <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic sel;
    assign sel = wren && (ch_sel == AW'(g));

    tick_timer_channel #(.W(W)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .we_count  (sel && (reg_sel == REG_COUNT)),
      .we_reload (sel && (reg_sel == REG_RELOAD)),
      .we_ctrl   (sel && (reg_sel == REG_CTRL)),
      .we_status (sel && (reg_sel == REG_STATUS)),
      .di        (di),
      .count     (count_a[g]),
      .reload    (reload_a[g]),
      .ctrl      (ctrl_a[g]),
      .exp       (exp_a[g]),
      .irq_req   (irq_req_a[g])
    );
  end

  // Channel indices beyond NCH match no entry and read back as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_COUNT:  rd_val = count_a[i];
          REG_RELOAD: rd_val = reload_a[i];
          REG_CTRL:   rd_val = W'(ctrl_a[i]);
          REG_STATUS: rd_val = W'({count_a[i] != '0, exp_a[i]});
          default:    rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      irq <= 1'b0;
    end else begin
      if (rden)
        q <= rd_val;
      irq <= |irq_req_a;
    end
  end

endmodule
